muldiv_unit: RTL and testbench

- Iterative multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- It is the multi-cycle responder counterpart to the combinational ALU: the control path issues a request with a start pulse and stalls until done.
- One shared shift/add-subtract datapath handles all eight M-extension operations.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_operand_prep.sv | 30 +++
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed1(input muldiv_op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_signed2(input muldiv_op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand front end: magnitudes, sign flags and special-case detection.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  muldiv_op_e       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] mag1_o,
  output logic [WIDTH-1:0] mag2_o,
  output logic             neg1_o,
  output logic             neg2_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    neg1_o     = is_signed1(op_i) & op1_i[WIDTH-1];
    neg2_o     = is_signed2(op_i) & op2_i[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1), which is correct as unsigned.
    mag1_o     = neg1_o ? ({WIDTH{1'b0}} - op1_i) : op1_i;
    mag2_o     = neg2_o ? ({WIDTH{1'b0}} - op2_i) : op2_i;
    div_zero_o = is_div(op_i) && (op2_i == '0);
    overflow_o = ((op_i == OpDiv) || (op_i == OpRem)) && (op1_i == MinNeg) && (op2_i == '1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sharing one shift/add-subtract datapath.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL* ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  muldiv_op_e       op_in;
  logic [WIDTH-1:0] mag1, mag2;
  logic             neg1, neg2, div_zero, overflow;

  assign op_in = muldiv_op_e'(op);

  muldiv_operand_prep #(
    .WIDTH(WIDTH)
  ) u_prep (
    .op_i      (op_in),
    .op1_i     (op1),
    .op2_i     (op2),
    .mag1_o    (mag1),
    .mag2_o    (mag2),
    .neg1_o    (neg1),
    .neg2_o    (neg2),
    .div_zero_o(div_zero),
    .overflow_o(overflow)
  );

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;

  // One iteration: shift-add for multiply (multiplier in the low half),
  // restoring shift-subtract for divide (remainder high, quotient low).
  function automatic logic [2*WIDTH-1:0] iterate(input logic               div,
                                                 input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]   opnd);
    logic [WIDTH:0]     part;
    logic [2*WIDTH-1:0] nxt;
    if (div) begin
      part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      if (part >= {1'b0, opnd}) begin
        part = part - {1'b0, opnd};
        nxt  = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        nxt  = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      part = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                    : {1'b0, acc[2*WIDTH-1:WIDTH]};
      nxt  = {part, acc[WIDTH-1:1]};
    end
    return nxt;
  endfunction

  // Sign fix and half/quotient/remainder selection.
  function automatic logic [WIDTH-1:0] finalize(input muldiv_op_e         o,
                                                input logic               neg,
                                                input logic [2*WIDTH-1:0] acc);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res;
    prod = neg ? ({(2*WIDTH){1'b0}} - acc) : acc;
    quo  = neg ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem  = neg ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    case (o)
      OpMul:                     res = prod[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: res = prod[2*WIDTH-1:WIDTH];
      OpDiv, OpDivu:             res = quo;
      default:                   res = rem;
    endcase
    return res;
  endfunction

  logic               fast_hit;
  logic [2*WIDTH-1:0] fast_acc;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fm_a, fm_b;
  logic signed [2*WIDTH+1:0] fm_p;
  logic                      fm_unused;

  assign fm_a      = {is_signed1(op_in) & op1[WIDTH-1], op1};
  assign fm_b      = {is_signed2(op_in) & op2[WIDTH-1], op2};
  assign fm_p      = fm_a * fm_b;
  assign fm_unused = ^fm_p[2*WIDTH+1:2*WIDTH];
  assign fast_hit  = !is_div(op_in);
  assign fast_acc  = fm_p[2*WIDTH-1:0];
`else
  assign fast_hit  = 1'b0;
  assign fast_acc  = '0;
`endif

  assign acc_step = iterate(is_div(op_q), acc_q, opnd_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op_in;
          // Special cases resolve straight to a registered done on the next edge.
          if (div_zero) begin
            result_d = finalize(op_in, 1'b0, {op1, {WIDTH{1'b1}}});
            done_d   = 1'b1;
            dbz_d    = 1'b1;
          end else if (overflow) begin
            result_d = finalize(op_in, 1'b0, {{WIDTH{1'b0}}, op1});
            done_d   = 1'b1;
          end else if (fast_hit) begin
            result_d = finalize(op_in, 1'b0, fast_acc);
            done_d   = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = CNT_W'(WIDTH);
            neg_d   = is_rem(op_in) ? neg1 : (neg1 ^ neg2);
            if (is_div(op_in)) begin
              acc_d  = {{WIDTH{1'b0}}, mag1};
              opnd_d = mag2;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, mag2};
              opnd_d = mag1;
            end
          end
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(2)) state_d = StFinish;
      end
      StFinish: begin
        // The last of the WIDTH iterations is folded into the finish cycle.
        acc_d    = acc_step;
        cnt_d    = cnt_q - CNT_W'(1);
        result_d = finalize(op_q, neg_q, acc_step);
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed expectations.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] op1, op2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .op1        (op1),
    .op2        (op2),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op (start sampled on the next edge), scrambles the inputs, waits for done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_dbz);
    int k;
    int busy_cnt;
    op = o; op1 = a; op2 = b; start = 1'b1;
    step();
    start = 1'b0; op = 3'b000; op1 = 32'hDEAD_BEEF; op2 = 32'h0;
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      k++;
    end
    check_eq({tag, " latency"}, k, exp_lat);
    check_eq({tag, " result"}, result, exp_res);
    check_eq({tag, " div_by_zero"}, div_by_zero, exp_dbz);
    check_eq({tag, " busy@done"}, busy, 1'b0);
    check_eq({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; op = '0; op1 = '0; op2 = '0;
    step();
    step();
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset done", done, 1'b0);
    check_eq("reset result", result, 32'h0);
    check_eq("reset dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    step();

    run_op("MUL 7*-3", OpMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat, 1'b0);
    run_op("MUL 2^16*2^16", OpMul, 32'h0001_0000, 32'h0001_0000, 32'h0, MulLat, 1'b0);
    run_op("MULHU -1*-1", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 1'b0);
    run_op("MULH -1*-1", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MulLat, 1'b0);
    run_op("MULHSU -1*2", OpMulhsu, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MulLat, 1'b0);
    run_op("MULH min*min", OpMulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat, 1'b0);
    run_op("DIV -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivLat, 1'b0);
    run_op("REM -7/2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivLat, 1'b0);
    run_op("DIV 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat, 1'b0);
    run_op("REM 7/-2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, DivLat, 1'b0);
    run_op("DIVU 100/7", OpDivu, 32'd100, 32'd7, 32'd14, DivLat, 1'b0);
    run_op("REMU 100/7", OpRemu, 32'd100, 32'd7, 32'd2, DivLat, 1'b0);
    run_op("DIVU max/1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, DivLat, 1'b0);
    run_op("DIVU 5/0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op("REM 5/0", OpRem, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    run_op("REM -5/0", OpRem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 1'b1);
    run_op("DIV ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("REM ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
    step();
    check_eq("done single pulse", done, 1'b0);

    // A start while busy must be ignored.
    op = OpDiv; op1 = 32'hFFFF_FFF9; op2 = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 100) begin
      if (k == 10) begin
        start = 1'b1; op = OpDivu; op1 = 32'd100; op2 = 32'd7;
      end else begin
        start = 1'b0;
      end
      step();
      k++;
    end
    start = 1'b0;
    check_eq("ignored start latency", k, DivLat);
    check_eq("ignored start result", result, 32'hFFFF_FFFD);
    // Start in the done cycle is accepted.
    run_op("b2b REMU", OpRemu, 32'd100, 32'd7, 32'd2, DivLat, 1'b0);

    // Asynchronous reset mid-multiply.
    op = OpMul; op1 = 32'd7; op2 = 32'hFFFF_FFFD; start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    check_eq("busy before reset", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("async reset busy", busy, 1'b0);
    check_eq("async reset result", result, 32'h0);
    check_eq("async reset done", done, 1'b0);
    k = 0;
    repeat (20) begin
      step();
      if (done === 1'b1) k++;
    end
    reset = 1'b0;
    step();
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) k++;
    end
    check_eq("no done after abort", k, 0);
    run_op("MUL after reset", OpMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
